muldiv_seq: RTL
===============

# muldiv_seq

Sequencer for the multi-cycle multiply/divide resource and owner of the HI/LO architectural registers.
- Accepts MULT/MULTU/DIV/DIVU operations from the execute side (decode-produced enable, signedness and operand signals).
- Iterates radix-2 shift-add (multiply) or restoring division (divide) over 32 cycles and applies sign correction.
- Holds `md_busy` so the pipeline stalls while the operation is in flight.
- Serves MFHI/MFLO reads and MTHI/MTLO writes.

## Interface
Parameters:
- `MUL_FAST`, default 0: when 1, a multiply completes in one CALC cycle using a combinational 32x32 product; divide is unaffected.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `md_mult_en` in 1: start a multiply; level is sampled each cycle.
- `md_div_en` in 1: start a divide.
- `md_is_signed` in 1: 1 = signed (MULT/DIV), 0 = unsigned.
- `md_src1` in 32: multiplicand or dividend (rs).
- `md_src2` in 32: multiplier or divisor (rt).
- `md_flush` in 1: abort any in-flight operation; exception or ERET flush.
- `hi_we` in 1: MTHI write.
- `lo_we` in 1: MTLO write.
- `hilo_wdata` in 32: data for `hi_we` / `lo_we`.
- `md_busy` out 1: operation in flight; the pipeline must stall.
- `md_done` out 1: one-cycle pulse; new HI/LO are visible this cycle.
- `md_hi` out 32: current HI.
- `md_lo` out 32: current LO.

## Operation
- States: IDLE, CALC, FIX.
- Start:
  - Occurs in IDLE when `(md_mult_en | md_div_en) & ~md_flush`.
  - Latches `md_src1`, `md_src2`, `md_is_signed` and the operation type; clears the iteration counter; next state is CALC.
  - If both enables are high, multiply wins.
  - Enables are ignored outside IDLE. The requester must drop the enable after one accepted cycle; a level still high when the block returns to IDLE starts a new operation.
- CALC (operation performed on operand magnitudes when signed):
  - Multiply: one shift-add step per cycle into a 64-bit accumulator.
  - Divide: one restoring step per cycle; 32-bit partial remainder, 33-bit trial subtract, quotient bit shifted into LO.
  - Exits to FIX after counter reaches 31 (32 cycles). With `MUL_FAST=1`, a multiply exits after 1 cycle.
- FIX: sign correction, then HI/LO written at the closing edge; next state is IDLE.
  - Signed multiply: negate the 64-bit product iff the operand signs differ.
  - Signed divide: negate the quotient iff the operand signs differ; the remainder takes the dividend's sign.
  - Result mapping: multiply gives HI = product[63:32], LO = product[31:0]; divide gives LO = quotient, HI = remainder.
  - Divisor == 0, either signedness: HI = src1 unchanged, LO = 0xFFFFFFFF. No exception is raised.
  - Signed 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Direct writes:
  - `hi_we` / `lo_we` update HI/LO at the next edge in any state.
  - In the FIX cycle, the result write wins over a direct write.
- Flush:
  - `md_flush` forces IDLE at the next edge from any state.
  - HI/LO are not modified by the aborted operation, and `md_done` is not asserted.
  - A flush in the same cycle as a start suppresses the start.
  - A flush does not block a same-cycle direct write.

## Timing
- Reset values: state IDLE, counter 0, `md_hi` = 0, `md_lo` = 0, `md_busy` = 0, `md_done` = 0. A reset mid-operation discards the operation and takes effect at the next edge.
- `md_busy` = (state != IDLE), decoded from registered state only, with no combinational path from the enables. The accept cycle itself is cycle 0 with `md_busy` = 0; the pipeline must advance past the MULT/DIV in that cycle.
- Normal op:
  - Accept at cycle 0.
  - CALC occupies cycles 1..32.
  - FIX is cycle 33.
  - `md_busy` is high in cycles 1..33.
  - `md_done` is high and new HI/LO are visible in cycle 34.
  - Back-to-back: a new start can be accepted in cycle 34.
- `MUL_FAST=1` multiply: CALC in cycle 1, FIX in cycle 2; `md_done` and new HI/LO in cycle 3.
- `md_done` is registered and high for exactly one cycle per completed operation.
- `md_hi` / `md_lo` are register outputs; a direct write is visible one cycle after `hi_we` / `lo_we`.

## Test plan
- Signed multiply: MULT src1=0xFFFFFFFE, src2=3.
  - Required: `md_busy` high in cycles 1..33; `md_done` in cycle 34 with HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- Unsigned multiply: MULTU 0xFFFFFFFF × 0xFFFFFFFF.
  - Required: HI=0xFFFFFFFE, LO=0x00000001.
  - Repeat with `MUL_FAST=1`: identical result, `md_done` in cycle 3.
- Divides:
  - DIV -7/2 (0xFFFFFFF9, 2) → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 7/2 → LO=3, HI=1.
  - DIV 7/-2 → LO=0xFFFFFFFD, HI=1.
- Divide corner cases:
  - DIVU 0x1234/0 → HI=0x1234, LO=0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- Flush, enables and direct writes:
  - `md_flush` in cycle 10 of a DIV → `md_busy` low in cycle 11, no `md_done`, HI/LO unchanged; an enable held high is re-accepted in cycle 11.
  - `md_mult_en` and `md_div_en` both high → multiply is performed.
  - `hi_we` in IDLE with 0xA5A5A5A5 → `md_hi`=0xA5A5A5A5 next cycle.
  - `lo_we` in the FIX cycle → result LO is kept.
- Reset mid-operation: `reset` in cycle 20 of a MULT → next cycle `md_busy`=0, `md_done`=0, HI=LO=0; a new MULT after reset completes normally in 34 cycles.

Source files
------------

// File: rtl/muldiv_seq_if.sv
// Execute-side handshake and HI/LO access bundle for the multiply/divide sequencer.
interface muldiv_seq_if;
  logic        md_mult_en;
  logic        md_div_en;
  logic        md_is_signed;
  logic [31:0] md_src1;
  logic [31:0] md_src2;
  logic        md_flush;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hilo_wdata;
  logic        md_busy;
  logic        md_done;
  logic [31:0] md_hi;
  logic [31:0] md_lo;

  modport master (
    output md_mult_en, md_div_en, md_is_signed, md_src1, md_src2, md_flush,
    output hi_we, lo_we, hilo_wdata,
    input  md_busy, md_done, md_hi, md_lo
  );

  modport slave (
    input  md_mult_en, md_div_en, md_is_signed, md_src1, md_src2, md_flush,
    input  hi_we, lo_we, hilo_wdata,
    output md_busy, md_done, md_hi, md_lo
  );
endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer and owner of HI/LO.
// Shift-add multiply and restoring divide run on operand magnitudes; signs are fixed in FIX.
module muldiv_seq #(
  parameter int MUL_FAST = 0
) (
  input logic         clk,
  input logic         reset,
  muldiv_seq_if.slave md
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  logic [1:0]  state, state_nx;
  logic [4:0]  cnt;
  logic        busy, done;
  logic        op_mul, op_signed;
  logic [31:0] src1, src2;
  logic [63:0] acc;
  logic [31:0] hi, lo;
  logic        start, calc_last, neg;
  logic [31:0] mag1, mag2, in_mag1, in_mag2;
  logic [32:0] mul_sum;
  logic [33:0] div_trial;
  logic [63:0] prod_fix;
  logic [31:0] res_hi, res_lo;

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

  assign start     = (state == ST_IDLE) && (md.md_mult_en || md.md_div_en) && !md.md_flush;
  assign calc_last = (cnt == 5'd31) || (op_mul && (MUL_FAST != 0));
  assign in_mag1   = mag32(md.md_src1, md.md_is_signed);
  assign in_mag2   = mag32(md.md_src2, md.md_is_signed);
  assign mag1      = mag32(src1, op_signed);
  assign mag2      = mag32(src2, op_signed);
  // acc is {partial product, multiplier} for multiply and {remainder, quotient} for divide
  assign mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag1} : 33'd0);
  assign div_trial = {1'b0, acc[63:32], acc[31]} - {2'b00, mag2};
  assign neg       = op_signed && (src1[31] ^ src2[31]);
  assign prod_fix  = neg ? (64'd0 - acc) : acc;

  // Next-state decode; a flush returns to IDLE from anywhere.
  always_comb begin
    state_nx = ST_IDLE;
    if (md.md_flush) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: state_nx = start ? ST_CALC : ST_IDLE;
        ST_CALC: state_nx = calc_last ? ST_FIX : ST_CALC;
        ST_FIX:  state_nx = ST_IDLE;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // Sign correction and HI/LO mapping of the finished accumulator.
  always_comb begin
    res_hi = prod_fix[63:32];
    res_lo = prod_fix[31:0];
    if (op_mul) begin
      res_hi = prod_fix[63:32];
      res_lo = prod_fix[31:0];
    end else if (src2 == 32'd0) begin
      res_hi = src1;
      res_lo = 32'hFFFF_FFFF;
    end else begin
      res_lo = neg ? (32'd0 - acc[31:0]) : acc[31:0];
      res_hi = (op_signed && src1[31]) ? (32'd0 - acc[63:32]) : acc[63:32];
    end
  end

  // Control state, busy/done flags and iteration counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      cnt   <= 5'd0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != ST_IDLE);
      done  <= (state == ST_FIX) && !md.md_flush;
      cnt   <= (state == ST_CALC) ? (cnt + 5'd1) : 5'd0;
    end
  end

  // Operand capture and one iteration step per CALC cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_mul    <= 1'b0;
      op_signed <= 1'b0;
      src1      <= 32'd0;
      src2      <= 32'd0;
      acc       <= 64'd0;
    end else if (start) begin
      op_mul    <= md.md_mult_en;
      op_signed <= md.md_is_signed;
      src1      <= md.md_src1;
      src2      <= md.md_src2;
      acc       <= {32'd0, (md.md_mult_en ? in_mag2 : in_mag1)};
    end else if (state == ST_CALC) begin
      if (op_mul && (MUL_FAST != 0)) begin
        acc <= {32'd0, mag1} * {32'd0, mag2};
      end else if (op_mul) begin
        acc <= {mul_sum, acc[31:1]};
      end else if (!div_trial[33]) begin
        acc <= {div_trial[31:0], acc[30:0], 1'b1};
      end else begin
        acc <= {acc[62:0], 1'b0};
      end
    end
  end

  // HI/LO: the FIX result write has priority over MTHI/MTLO.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if ((state == ST_FIX) && !md.md_flush) begin
      hi <= res_hi;
      lo <= res_lo;
    end else begin
      if (md.hi_we) begin
        hi <= md.hilo_wdata;
      end
      if (md.lo_we) begin
        lo <= md.hilo_wdata;
      end
    end
  end

  assign md.md_busy = busy;
  assign md.md_done = done;
  assign md.md_hi   = hi;
  assign md.md_lo   = lo;
endmodule
